dmmu_pt_loader: RTL and testbench

- Context-switch sequencer for the data MMU page table.
- On a start command it fetches 16 page-table entries from main memory over a req/ack read port.
- It writes them into the DMMU translation registers at SR 0x200..0x20F, then re-enables paging.
- Sits between the core's SR write port and the DMMU: it owns the SR port while loading and passes core writes through while idle.

---
 rtl/dmmu_pt_loader_pkg.sv | 27 ++
 rtl/dmmu_sr_mux.sv | 45 ++++
 rtl/dmmu_pt_loader.sv | 214 +++++++++++++++++++++
 tb/tb_dmmu_pt_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmmu_pt_loader_pkg.sv
// dmmu_pt_loader_pkg
//   Shared definitions for the DMMU page-table loader: default widths, the
//   SR addresses of the translation registers and paging control register,
//   the page-disable prefix shared with the DMMU, and the loader FSM states.
//   Optional feature macro: DMMU_PT_LOADER_CSUM_EN (adds the CHECK state).
package dmmu_pt_loader_pkg;

    localparam int unsigned MEM_AW       = 24;
    localparam int unsigned ENTRY_W      = 13;
    localparam logic [15:0] PT_SR_BASE   = 16'h0200;
    localparam logic [15:0] CTRL_SR_ADDR = 16'h0210;

    // Upper SR address byte the DMMU decodes as "page disable"; shared so
    // both blocks agree on the SR map.
    localparam logic [7:0]  PAG_DIS_PREFIX = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WRITE = 3'd2,
`ifdef DMMU_PT_LOADER_CSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dmmu_sr_mux.sv
// dmmu_sr_mux
//   SR write port multiplexer in front of the DMMU.
//   Idle: core SR writes pass straight through (combinational).
//   Busy: the loader owns the port; core writes are dropped. Dropped writes
//   to any address other than the control register are flagged on o_drop.
//   A core write to the control register while idle is flagged on o_ctrl_we.
// Ports:
//   i_busy                       loader owns the port
//   i_cpu_sr_addr/data/we        core SR write request
//   i_ld_sr_addr/data/we         loader SR write request
//   o_sr_addr/data/we            to DMMU
//   o_drop                       core write discarded (error)
//   o_ctrl_we                    idle core write to CTRL_SR_ADDR
module dmmu_sr_mux #(
    parameter int unsigned     RW           = 16,
    parameter logic [RW-1:0]   CTRL_SR_ADDR = RW'(dmmu_pt_loader_pkg::CTRL_SR_ADDR)
) (
    input  logic          i_busy,
    input  logic [RW-1:0] i_cpu_sr_addr,
    input  logic [RW-1:0] i_cpu_sr_data,
    input  logic          i_cpu_sr_we,
    input  logic [RW-1:0] i_ld_sr_addr,
    input  logic [RW-1:0] i_ld_sr_data,
    input  logic          i_ld_sr_we,
    output logic [RW-1:0] o_sr_addr,
    output logic [RW-1:0] o_sr_data,
    output logic          o_sr_we,
    output logic          o_drop,
    output logic          o_ctrl_we
);

    logic w_is_ctrl;

    assign w_is_ctrl = (i_cpu_sr_addr == CTRL_SR_ADDR);

    assign o_sr_addr = i_busy ? i_ld_sr_addr : i_cpu_sr_addr;
    assign o_sr_data = i_busy ? i_ld_sr_data : i_cpu_sr_data;
    assign o_sr_we   = i_busy ? i_ld_sr_we   : i_cpu_sr_we;

    // A control write while busy is discarded silently: it must not re-enable
    // paging mid-load, and it is not a translation-register conflict.
    assign o_drop    = i_busy && i_cpu_sr_we && !w_is_ctrl;
    assign o_ctrl_we = !i_busy && i_cpu_sr_we && w_is_ctrl;

endmodule

// File: rtl/dmmu_pt_loader.sv
// dmmu_pt_loader
//   Context-switch sequencer for the data MMU page table. On i_start it
//   fetches ENTRIES words from memory (req/ack), writes each, masked to
//   ENTRY_W bits, to SR PT_SR_BASE+index, then re-enables paging.
//   Optional feature macro: DMMU_PT_LOADER_CSUM_EN -- also fetches word
//   base+ENTRIES and requires it to equal the XOR of all fetched words.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_base, i_abort     load control
//   i_cpu_sr_addr/data/we        core SR write port
//   o_mem_req/addr, i_mem_ack/data   memory read port
//   o_sr_addr/data/we, o_pag_en  to DMMU
//   o_busy, o_done, o_err        status (done/err are one-cycle pulses)
module dmmu_pt_loader #(
    parameter int unsigned   RW           = 16,
    parameter int unsigned   MEM_AW       = dmmu_pt_loader_pkg::MEM_AW,
    parameter int unsigned   ENTRIES      = 16,
    parameter int unsigned   ENTRY_W      = dmmu_pt_loader_pkg::ENTRY_W,
    parameter logic [RW-1:0] PT_SR_BASE   = RW'(dmmu_pt_loader_pkg::PT_SR_BASE),
    parameter logic [RW-1:0] CTRL_SR_ADDR = RW'(dmmu_pt_loader_pkg::CTRL_SR_ADDR)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [MEM_AW-1:0] i_base,
    input  logic              i_abort,
    input  logic [RW-1:0]     i_cpu_sr_addr,
    input  logic [RW-1:0]     i_cpu_sr_data,
    input  logic              i_cpu_sr_we,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [RW-1:0]     i_mem_data,
    output logic [RW-1:0]     o_sr_addr,
    output logic [RW-1:0]     o_sr_data,
    output logic              o_sr_we,
    output logic              o_pag_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    import dmmu_pt_loader_pkg::*;

    localparam int unsigned   IW       = $clog2(ENTRIES);
    localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_index;
    logic [MEM_AW-1:0]   r_base;
    logic [RW-1:0]       r_entry;
    logic                r_pag_en;
    logic                r_err;
    logic                w_last;
    logic                w_abort;
    logic                w_csum_fail;
    logic                w_ld_we;
    logic [RW-1:0]       w_ld_addr;
    logic                w_drop;
    logic                w_ctrl_we;
`ifdef DMMU_PT_LOADER_CSUM_EN
    logic [RW-1:0]       r_xor;
`else
    logic                w_unused_mem;
    assign w_unused_mem = ^i_mem_data;
`endif

    assign w_last = (r_index == LAST_IDX);

    // Next state. Abort is only honoured in the fetch/write/check states and
    // overrides an ack or a write in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_abort     = 1'b0;
        w_csum_fail = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_REQ;
            end
            ST_REQ: begin
                w_abort = i_abort;
                if (i_abort)        w_next = ST_IDLE;
                else if (i_mem_ack) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_abort = i_abort;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
`ifdef DMMU_PT_LOADER_CSUM_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_DONE;
`endif
                end else begin
                    w_next = ST_REQ;
                end
            end
`ifdef DMMU_PT_LOADER_CSUM_EN
            ST_CHECK: begin
                w_abort = i_abort;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_mem_ack) begin
                    if (i_mem_data == r_xor) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next      = ST_IDLE;
                        w_csum_fail = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Memory read port: address held from state registers, so it is stable
    // for the whole wait.
    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_addr = '0;
        case (r_state)
            ST_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_base + MEM_AW'(r_index);
            end
`ifdef DMMU_PT_LOADER_CSUM_EN
            ST_CHECK: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_base + MEM_AW'(ENTRIES);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_index  <= '0;
            r_base   <= '0;
            r_entry  <= '0;
            r_pag_en <= 1'b0;
            r_err    <= 1'b0;
`ifdef DMMU_PT_LOADER_CSUM_EN
            r_xor    <= '0;
`endif
        end else begin
            r_err <= w_drop || w_abort || w_csum_fail;
            case (r_state)
                ST_IDLE: begin
                    // Start beats a same-cycle control write: paging stays off.
                    if (i_start) begin
                        r_base   <= i_base;
                        r_index  <= '0;
                        r_pag_en <= 1'b0;
`ifdef DMMU_PT_LOADER_CSUM_EN
                        r_xor    <= '0;
`endif
                    end else if (w_ctrl_we) begin
                        r_pag_en <= i_cpu_sr_data[0];
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack && !i_abort) begin
                        r_entry <= RW'(i_mem_data[ENTRY_W-1:0]);
`ifdef DMMU_PT_LOADER_CSUM_EN
                        r_xor   <= r_xor ^ i_mem_data;
`endif
                    end
                end
                ST_WRITE: begin
                    if (!i_abort && !w_last) r_index <= r_index + IW'(1);
                end
                ST_DONE: r_pag_en <= 1'b1;
                default: ;
            endcase
        end
    end

    assign w_ld_we   = (r_state == ST_WRITE) && !i_abort;
    assign w_ld_addr = PT_SR_BASE + RW'(r_index);

    dmmu_sr_mux #(
        .RW           (RW),
        .CTRL_SR_ADDR (CTRL_SR_ADDR)
    ) u_sr_mux (
        .i_busy        (o_busy),
        .i_cpu_sr_addr (i_cpu_sr_addr),
        .i_cpu_sr_data (i_cpu_sr_data),
        .i_cpu_sr_we   (i_cpu_sr_we),
        .i_ld_sr_addr  (w_ld_addr),
        .i_ld_sr_data  (r_entry),
        .i_ld_sr_we    (w_ld_we),
        .o_sr_addr     (o_sr_addr),
        .o_sr_data     (o_sr_data),
        .o_sr_we       (o_sr_we),
        .o_drop        (w_drop),
        .o_ctrl_we     (w_ctrl_we)
    );

    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_DONE);
    assign o_err    = r_err;
    assign o_pag_en = r_pag_en;

endmodule

// File: tb/tb_dmmu_pt_loader.sv
// tb_dmmu_pt_loader
//   Directed bench for dmmu_pt_loader. A memory responder serves reads with
//   a configurable ack latency; a transaction-level model (expected address
//   and SR write lists, completion cycle, paging/err expectations) is checked
//   against the DUT on every negative clock edge, and literal expectations
//   pin the model after each scenario.
//   Define DMMU_PT_LOADER_CSUM_EN for the checksum build.
module tb_dmmu_pt_loader;

    localparam int N = 16;
`ifdef DMMU_PT_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] base;
    logic        abort_i;
    logic [15:0] cpu_addr, cpu_data;
    logic        cpu_we;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] sr_addr, sr_data;
    logic        sr_we, pag_en, busy, done, err;

    dmmu_pt_loader dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_base        (base),
        .i_abort       (abort_i),
        .i_cpu_sr_addr (cpu_addr),
        .i_cpu_sr_data (cpu_data),
        .i_cpu_sr_we   (cpu_we),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_ack     (mem_ack),
        .i_mem_data    (mem_data),
        .o_sr_addr     (sr_addr),
        .o_sr_data     (sr_data),
        .o_sr_we       (sr_we),
        .o_pag_en      (pag_en),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory ----------------
    logic [15:0] mem [logic [23:0]];
    int lat = 0;

    function automatic logic [15:0] rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    initial begin
        int wcnt;
        wcnt     = 0;
        mem_ack  = 1'b0;
        mem_data = 16'hDEAD;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (wcnt == lat) begin
                    mem_ack  = 1'b1;
                    mem_data = rd(mem_addr);
                    wcnt     = 0;
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = 16'hDEAD;
                    wcnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                mem_data = 16'hDEAD;
                wcnt     = 0;
            end
        end
    end

    // ---------------- model + compare ----------------
    int          cyc          = 0;
    int          s_cyc        = -1000;
    int          busy_end     = -1000;
    int          exp_done_cyc = -1;
    int          exp_err_cyc  = -1;
    bit          err_pend     = 1'b0;
    bit          exp_pag      = 1'b0;
    int          wr_cnt       = 0;
    int          done_delay   = -1;
    logic [23:0] exp_ma_q [$];
    logic [31:0] exp_wr_q [$];
    logic [23:0] ma_log   [$];
    logic [31:0] wr_log   [$];

    task automatic model_flush();
        exp_ma_q.delete();
        exp_wr_q.delete();
        exp_done_cyc = -1;
        exp_err_cyc  = -1;
        busy_end     = cyc;
    endtask

    task automatic model_start(input logic [23:0] b);
        logic [15:0] x;
        logic [23:0] a;
        int t;
        exp_ma_q.delete();
        exp_wr_q.delete();
        ma_log.delete();
        wr_log.delete();
        wr_cnt     = 0;
        done_delay = -1;
        s_cyc      = cyc;
        x          = 16'h0000;
        for (int k = 0; k < N; k++) begin
            a = b + 24'(k);
            exp_ma_q.push_back(a);
            exp_wr_q.push_back({16'h0200 + 16'(k), rd(a) & 16'h1FFF});
            x = x ^ rd(a);
        end
        // One REQ (lat+1 cycles) and one WRITE per entry, then DONE.
        t = N * (lat + 2) + 1;
        exp_err_cyc = -1;
        if (CSUM) begin
            t = t + lat + 1;
            exp_ma_q.push_back(b + 24'(N));
            if (rd(b + 24'(N)) == x) begin
                exp_done_cyc = cyc + t;
                busy_end     = cyc + t;
            end else begin
                exp_done_cyc = -1;
                busy_end     = cyc + t - 1;
                exp_err_cyc  = cyc + t;
            end
        end else begin
            exp_done_cyc = cyc + t;
            busy_end     = cyc + t;
        end
    endtask

    always @(negedge clk) begin
        bit m_busy;
        bit nerr;
        bit npag;
        cyc++;
        m_busy = (cyc > s_cyc) && (cyc <= busy_end);
        check("busy", busy, m_busy);
        check("done", done, cyc == exp_done_cyc);
        check("err", err, err_pend || (cyc == exp_err_cyc));
        check("pag_en", pag_en, exp_pag);
        if (mem_req) begin
            check("mem_req_expected", exp_ma_q.size() != 0, 1);
            if (exp_ma_q.size() != 0) begin
                check("mem_addr", mem_addr, exp_ma_q[0]);
                if (mem_ack) begin
                    ma_log.push_back(mem_addr);
                    void'(exp_ma_q.pop_front());
                end
            end
        end
        if (m_busy) begin
            if (sr_we) begin
                check("sr_write_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    check("sr_write", {sr_addr, sr_data}, exp_wr_q[0]);
                    void'(exp_wr_q.pop_front());
                end
                wr_log.push_back({sr_addr, sr_data});
                wr_cnt++;
            end
        end else begin
            check("sr_pass", {sr_we, sr_addr, sr_data}, {cpu_we, cpu_addr, cpu_data});
        end

        nerr = 1'b0;
        npag = exp_pag;
        if (rst) begin
            model_flush();
            npag = 1'b0;
        end else begin
            if (!m_busy && start) begin
                model_start(base);
                npag = 1'b0;
            end else if (!m_busy && cpu_we && cpu_addr == 16'h0210) begin
                npag = cpu_data[0];
            end
            if (m_busy && cpu_we && cpu_addr != 16'h0210) nerr = 1'b1;
            if (m_busy && abort_i && cyc != exp_done_cyc) begin
                model_flush();
                nerr = 1'b1;
            end
            if (cyc == exp_done_cyc) begin
                npag       = 1'b1;
                done_delay = cyc - s_cyc;
                check("writes_left_at_done", exp_wr_q.size(), 0);
            end
        end
        err_pend = nerr;
        exp_pag  = npag;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [23:0] b, input logic [15:0] w0, input bit good_csum);
        logic [15:0] x;
        x = 16'h0000;
        for (int k = 0; k < N; k++) begin
            mem[b + 24'(k)] = w0 + 16'(k);
            x = x ^ (w0 + 16'(k));
        end
        mem[b + 24'(N)] = good_csum ? x : (x ^ 16'h0040);
    endtask

    task automatic pulse_start(input logic [23:0] b);
        base  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; abort_i = 1'b0;
        cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pag_en", pag_en, 0);
        check("rst_done_err", {done, err, sr_we}, 0);
        rst = 1'b0;
        tick();

        // Zero-wait load from 0x001000.
        lat = 0;
        fill(24'h001000, 16'h1000, 1'b1);
        pulse_start(24'h001000);
        wait_idle(200);
        check("t1_done_cycle", done_delay, CSUM ? 34 : 33);
        check("t1_writes", wr_cnt, 16);
        check("t1_first_wr", wr_log[0], 32'h0200_1000);
        check("t1_last_wr", wr_log[15], 32'h020F_100F);
        check("t1_pag_en", pag_en, 1);

        // Three wait states, address wrap, core write dropped while busy.
        lat = 3;
        fill(24'hFFFFFC, 16'hE0A0, 1'b1);
        pulse_start(24'hFFFFFC);
        tick(); tick();
        cpu_addr = 16'h0205; cpu_data = 16'hBEEF; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        check("t2_drop_err", err, 1);
        wait_idle(300);
        check("t2_done_cycle", done_delay, CSUM ? 85 : 81);
        check("t2_addr0", ma_log[0], 24'hFFFFFC);
        check("t2_addr4", ma_log[4], 24'h000000);
        check("t2_addr15", ma_log[15], 24'h00000B);
        check("t2_first_wr", wr_log[0], 32'h0200_00A0);
        check("t2_writes", wr_cnt, 16);

        // Control register writes while idle are forwarded and set paging.
        cpu_addr = 16'h0210; cpu_data = 16'h0000; cpu_we = 1'b1;
        tick();
        check("ctrl0_pag_en", pag_en, 0);
        cpu_data = 16'h0001;
        #1;
        check("ctrl1_fwd", {sr_we, sr_addr, sr_data}, {1'b1, 16'h0210, 16'h0001});
        tick();
        cpu_we = 1'b0;
        check("ctrl1_pag_en", pag_en, 1);

        // Abort in the REQ of entry 5 with a same-cycle ack; start and a
        // CTRL write collide (start wins).
        lat = 0;
        fill(24'h002000, 16'h7F30, 1'b1);
        cpu_addr = 16'h0210; cpu_data = 16'h0001; cpu_we = 1'b1;
        pulse_start(24'h002000);
        cpu_we = 1'b0;
        check("t3_pag_off", pag_en, 0);
        for (int i = 0; i < 100; i++) begin
            if (mem_req && mem_addr == 24'h002005) break;
            tick();
        end
        check("t3_reached_entry5", mem_addr, 24'h002005);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t3_err", err, 1);
        check("t3_idle", busy, 0);
        check("t3_writes", wr_cnt, 5);
        check("t3_pag_en", pag_en, 0);
        tick(); tick();
        pulse_start(24'h002000);
        wait_idle(200);
        check("t3_restart_addr0", ma_log[0], 24'h002000);
        check("t3_restart_writes", wr_cnt, 16);
        check("t3_restart_pag", pag_en, 1);

        // Reset during the WRITE of entry 3.
        fill(24'h003000, 16'h0123, 1'b1);
        pulse_start(24'h003000);
        for (int i = 0; i < 100; i++) begin
            if (sr_we && sr_addr == 16'h0203) break;
            tick();
        end
        check("t5_reached_write3", {sr_we, sr_addr}, {1'b1, 16'h0203});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_mem", {mem_req, mem_addr}, 0);
        check("t5_flags", {sr_we, pag_en, done, err}, 0);
        tick(); tick();

`ifdef DMMU_PT_LOADER_CSUM_EN
        // Checksum word corrupted by one bit.
        fill(24'h004000, 16'h5A00, 1'b0);
        pulse_start(24'h004000);
        wait_idle(200);
        check("t6_err", err, 1);
        check("t6_writes", wr_cnt, 16);
        check("t6_pag_en", pag_en, 0);
        check("t6_no_done", done_delay, -1);
        tick();
`endif

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
